// File: rtl/dense_weight_server.sv
// Weight memory for the dense forward/backward blocks.
// Read port: one registered word per cycle, one cycle after the address.
// Load port: a scalar valid/ready stream is packed DENSE_DATA_N scalars per word,
// with the first scalar placed in the LSBs.
//
// state | meaning
// IDLE  | no load in progress; the scalar stream is not accepted
// LOAD  | accepting scalars, packing them and writing full words
// DONE  | last word written; pulses load_done, then returns to IDLE

`ifndef HID_DIM
`define HID_DIM 16
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 8
`endif
`ifndef N_LEN
`define N_LEN 16
`endif

module dense_weight_server #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DENSE_DATA_N = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_WIDTH-1:0]            raddr,
   output logic [DENSE_DATA_N*`N_LEN-1:0]   rdata,
   input  logic                             load_start,
   input  logic                             wvalid,
   output logic                             wready,
   input  logic [`N_LEN-1:0]                wdata,
   output logic                             loading,
   output logic                             load_done,
   output logic                             loaded
);

   localparam int N_LEN  = `N_LEN;
   localparam int WORD_W = DENSE_DATA_N * N_LEN;
   localparam int WORDS  = `HID_DIM * `CHAR_NUM / DENSE_DATA_N;
   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int LANE_W = (DENSE_DATA_N > 1) ? $clog2(DENSE_DATA_N) : 1;

   localparam logic [LANE_W-1:0]     LAST_LANE  = LANE_W'(DENSE_DATA_N - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(WORDS - 1);
   localparam logic [ADDR_WIDTH:0]   WORDS_EXT  = (ADDR_WIDTH + 1)'(WORDS);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   waddr;
   logic [LANE_W-1:0]       lane;
   logic [WORD_W-1:0]       pack;
   logic [WORD_W-1:0]       word_next;
   logic                    mem_we;
   logic                    raddr_ok;

   logic [WORD_W-1:0]       mem [0:WORDS-1];

   // Pack register with the incoming scalar merged into the current lane.
   always_comb begin
      word_next = pack;
      word_next[lane*N_LEN +: N_LEN] = wdata;
   end

   // A restart in the same cycle wins over the scalar, so no word is written then.
   assign mem_we   = (state == LOAD) && wvalid && !load_start && (lane == LAST_LANE);
   assign raddr_ok = ({1'b0, raddr} < WORDS_EXT);

   // Word write; the memory is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[waddr[IDX_W-1:0]] <= word_next;
   end

   // Registered read; a same-cycle write is not forwarded, so the old word comes back.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (raddr_ok)
         rdata <= mem[raddr[IDX_W-1:0]];
      else
         rdata <= '0;
   end

   // Load sequencer with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         waddr     <= '0;
         lane      <= '0;
         pack      <= '0;
         wready    <= 1'b0;
         loading   <= 1'b0;
         load_done <= 1'b0;
         loaded    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               load_done <= 1'b0;
               if (load_start) begin
                  state   <= LOAD;
                  waddr   <= '0;
                  lane    <= '0;
                  pack    <= '0;
                  loaded  <= 1'b0;
                  wready  <= 1'b1;
                  loading <= 1'b1;
               end
            end
            LOAD: begin
               if (load_start) begin
                  waddr <= '0;
                  lane  <= '0;
                  pack  <= '0;
               end else if (wvalid) begin
                  pack <= word_next;
                  if (lane == LAST_LANE) begin
                     lane  <= '0;
                     waddr <= waddr + 1'b1;
                     if (waddr == LAST_WORD) begin
                        state     <= DONE;
                        wready    <= 1'b0;
                        loading   <= 1'b0;
                        load_done <= 1'b1;
                     end
                  end else begin
                     lane <= lane + 1'b1;
                  end
               end
            end
            DONE: begin
               load_done <= 1'b0;
               if (load_start) begin
                  state   <= LOAD;
                  waddr   <= '0;
                  lane    <= '0;
                  pack    <= '0;
                  wready  <= 1'b1;
                  loading <= 1'b1;
               end else begin
                  state  <= IDLE;
                  loaded <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               wready    <= 1'b0;
               loading   <= 1'b0;
               load_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dense_weight_server.sv
// Bench for dense_weight_server: directed loads and reads; read data is checked
// by a scoreboard monitor, status outputs are checked inline by the driver.

`ifndef HID_DIM
`define HID_DIM 16
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 8
`endif
`ifndef N_LEN
`define N_LEN 16
`endif

module tb_dense_weight_server;

   localparam int AW    = 10;
   localparam int N     = 8;
   localparam int NL    = `N_LEN;
   localparam int W     = N * NL;
   localparam int WORDS = `HID_DIM * `CHAR_NUM / N;
   localparam int TOTAL = WORDS * N;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [AW-1:0]   raddr = '0;
   logic [W-1:0]    rdata;
   logic            load_start = 1'b0;
   logic            wvalid = 1'b0;
   logic            wready;
   logic [NL-1:0]   wdata = '0;
   logic            loading;
   logic            load_done;
   logic            loaded;

   logic            chk = 1'b0;
   logic            chk_d;
   logic [W-1:0]    exp_q[$];
   int              tests = 0;
   int              fails = 0;
   int              done_cnt = 0;
   int              done_exp = 0;

   dense_weight_server #(.ADDR_WIDTH(AW), .DENSE_DATA_N(N)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
      .load_start(load_start), .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .loading(loading), .load_done(load_done), .loaded(loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (load_done === 1'b1) done_cnt++;

   function automatic logic [NL-1:0] val(input int pat, input int i);
      case (pat)
         0:       return NL'(i);
         1:       return NL'(16'hB000 + i * 3);
         default: return NL'(16'hC000 + i);
      endcase
   endfunction

   function automatic logic [W-1:0] word_of(input int pat, input int k);
      logic [W-1:0] w;
      w = '0;
      for (int j = 0; j < N; j++) w[j*NL +: NL] = val(pat, k * N + j);
      return w;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: rdata for an address driven before edge t is compared after edge t.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         chk_d = chk;
         #1;
         if (chk_d) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rdata_unexpected: got %h with no pending expectation", rdata);
            end else begin
               e = exp_q.pop_front();
               check("rdata", rdata, e);
            end
         end
      end
   end

   task automatic rd(input int a, input logic [W-1:0] e);
      @(negedge clk);
      raddr = AW'(a);
      chk = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic rd_end();
      @(negedge clk);
      chk = 1'b0;
   endtask

   task automatic sweep(input int pat);
      for (int k = 0; k < WORDS; k++) rd(k, word_of(pat, k));
      rd(WORDS, '0);
      rd((1 << AW) - 1, '0);
      rd_end();
   endtask

   // Starts a load and streams n scalars of pattern pat; optional gaps and a mem[3] collision read.
   task automatic load(input int pat, input int n, input bit bubbly, input bit junk,
                       input int coll_idx, input int prev_pat);
      @(negedge clk);
      load_start = 1'b1;
      wvalid = junk;
      wdata = 16'hFFFF;
      @(negedge clk);
      load_start = 1'b0;
      wvalid = 1'b0;
      check("wready_after_start", W'(wready), W'(1));
      check("loading_after_start", W'(loading), W'(1));
      check("loaded_after_start", W'(loaded), W'(0));
      for (int i = 0; i < n; i++) begin
         if (bubbly && (i % 5 == 2)) begin
            for (int g = 0; g <= i % 3; g++) begin
               @(negedge clk);
               wvalid = 1'b0;
               chk = 1'b0;
               check("wready_in_gap", W'(wready), W'(1));
            end
         end
         @(negedge clk);
         wvalid = 1'b1;
         wdata = val(pat, i);
         chk = 1'b0;
         if (i == coll_idx) begin
            raddr = AW'(3);
            chk = 1'b1;
            exp_q.push_back(word_of(prev_pat, 3));
         end else if (coll_idx >= 0 && i == coll_idx + 1) begin
            raddr = AW'(3);
            chk = 1'b1;
            exp_q.push_back(word_of(pat, 3));
         end
      end
      @(negedge clk);
      wvalid = 1'b0;
      chk = 1'b0;
   endtask

   task automatic finish_full();
      done_exp++;
      check("load_done_pulse", W'(load_done), W'(1));
      check("wready_in_done", W'(wready), W'(0));
      check("loaded_in_done", W'(loaded), W'(0));
      @(negedge clk);
      check("load_done_low", W'(load_done), W'(0));
      check("loaded_set", W'(loaded), W'(1));
      check("loading_low", W'(loading), W'(0));
      check("load_done_count", W'(done_cnt), W'(done_exp));
   endtask

   initial begin
      // 1) reset, then stray scalars in IDLE
      repeat (2) @(negedge clk);
      check("rst_rdata", rdata, '0);
      check("rst_wready", W'(wready), W'(0));
      check("rst_loaded", W'(loaded), W'(0));
      check("rst_load_done", W'(load_done), W'(0));
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wvalid = 1'b1;
         wdata = 16'h5A5A;
         check("idle_wready", W'(wready), W'(0));
      end
      @(negedge clk);
      wvalid = 1'b0;

      // 2) full back-to-back load of pattern A, with a scalar offered alongside load_start
      load(0, TOTAL, 1'b0, 1'b1, -1, 0);
      finish_full();

      // 3) streaming read sweep, including out-of-range addresses
      sweep(0);

      // 5) restart after 13 scalars of pattern C, then full load of pattern B
      load(2, 13, 1'b0, 1'b1, -1, 0);
      load(1, TOTAL, 1'b0, 1'b0, -1, 0);
      finish_full();
      sweep(1);

      // 4) bubbly load of pattern A
      load(0, TOTAL, 1'b1, 1'b0, -1, 0);
      finish_full();
      sweep(0);

      // 6) collision on word 3 during a load of B, then reset at the half-load point
      load(1, TOTAL / 2, 1'b0, 1'b0, 3 * N + N - 1, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_loaded", W'(loaded), W'(0));
      check("midrst_wready", W'(wready), W'(0));
      check("midrst_loading", W'(loading), W'(0));
      check("midrst_rdata", rdata, '0);
      rd(2, word_of(1, 2));
      rd(WORDS / 2 - 1, word_of(1, WORDS / 2 - 1));
      rd(WORDS / 2, word_of(0, WORDS / 2));
      rd(WORDS - 1, word_of(0, WORDS - 1));
      rd_end();
      repeat (3) @(negedge clk);
      check("scoreboard_drained", W'(exp_q.size()), W'(0));
      check("final_done_count", W'(done_cnt), W'(done_exp));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
